// File: rtl/shift_pkg.sv
// Shared mode and direction encodings for the universal shift register family.
package shift_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control and data bundle for univ_shift_reg; master drives operations, slave is the register.
interface univ_shift_reg_if #(
   parameter int WIDTH = 4
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic             en;
   logic [1:0]       mode;
   logic             serial_in;
   logic [WIDTH-1:0] parallel_in;
   logic [WIDTH-1:0] parallel_out;
   logic             serial_out;
   logic             word_done;
   logic [CNT_W-1:0] shift_cnt;

   modport master (
      output en, mode, serial_in, parallel_in,
      input  parallel_out, serial_out, word_done, shift_cnt
   );

   modport slave (
      input  en, mode, serial_in, parallel_in,
      output parallel_out, serial_out, word_done, shift_cnt
   );

endinterface

// File: rtl/shift_word_counter.sv
// Counts same-direction shifts and emits a registered one-cycle pulse per completed word.
module shift_word_counter #(
   parameter int WIDTH = 4,
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             shift,
   input  logic             dir_change,
   input  logic             clear,
   output logic [CNT_W-1:0] shift_cnt,
   output logic             word_done
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   always_ff @(posedge clk) begin
      if (reset) begin
         shift_cnt <= '0;
         word_done <= 1'b0;
      end else if (clear) begin
         shift_cnt <= '0;
         word_done <= 1'b0;
      end else if (shift) begin
         // A reversal abandons the partial word and is itself the first shift of a new one.
         if (dir_change) begin
            shift_cnt <= CNT_W'(1);
            word_done <= 1'b0;
         end else if (shift_cnt == LAST) begin
            shift_cnt <= '0;
            word_done <= 1'b1;
         end else begin
            shift_cnt <= shift_cnt + CNT_W'(1);
            word_done <= 1'b0;
         end
      end else begin
         word_done <= 1'b0;
      end
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register: hold, shift right, shift left, parallel load, with word counting.
module univ_shift_reg
   import shift_pkg::*;
#(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input logic             clk,
   input logic             reset,
   univ_shift_reg_if.slave bus
);

   logic [WIDTH-1:0] q;
   logic             dir;
   logic             shift;
   logic             new_dir;
   logic             dir_change;
   logic             clear;

   assign shift      = bus.en && ((bus.mode == MODE_SHR) || (bus.mode == MODE_SHL));
   assign new_dir    = (bus.mode == MODE_SHL) ? DIR_LEFT : DIR_RIGHT;
   assign dir_change = shift && (new_dir != dir);
   assign clear      = bus.en && (bus.mode == MODE_LOAD);

   always_ff @(posedge clk) begin
      if (reset) begin
         q   <= RESET_VAL;
         dir <= DIR_RIGHT;
      end else if (bus.en) begin
         case (bus.mode)
            MODE_SHR: begin
               q   <= {bus.serial_in, q[WIDTH-1:1]};
               dir <= DIR_RIGHT;
            end
            MODE_SHL: begin
               q   <= {q[WIDTH-2:0], bus.serial_in};
               dir <= DIR_LEFT;
            end
            MODE_LOAD: q <= bus.parallel_in;
            default: begin
            end
         endcase
      end
   end

   // Serial output tracks whichever end the last shift was moving toward.
   assign bus.parallel_out = q;
   assign bus.serial_out   = (dir == DIR_LEFT) ? q[WIDTH-1] : q[0];

   shift_word_counter #(
      .WIDTH(WIDTH)
   ) u_counter (
      .clk       (clk),
      .reset     (reset),
      .shift     (shift),
      .dir_change(dir_change),
      .clear     (clear),
      .shift_cnt (bus.shift_cnt),
      .word_done (bus.word_done)
   );

endmodule
